// File: rtl/cla_pkg.sv
// Shared constants and helpers for the CLA datapath blocks.
package cla_pkg;

  localparam int DATA_W = 16;

  // Width needed to count 0 .. 2*stages words.
  function automatic int cnt_w(input int stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/elastic_pipe_reg_skid_stage.sv
// One elastic stage: main register plus a skid register.
// Upstream ready comes from registers only, so no ready path crosses the stage.
module skid_stage #(
  parameter int               WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             Rs,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic             m_v;
  logic             s_v;
  logic [WIDTH-1:0] main_data;
  logic [WIDTH-1:0] skid_data;
  logic             accept;

  assign in_ready  = Rs & ~s_v;
  assign out_valid = m_v;
  assign out_data  = main_data;
  assign accept    = in_valid & in_ready;

  // The skid only fills while main is stalled, and always drains back into main first.
  always_ff @(posedge clk or negedge Rs) begin
    if (!Rs) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (flush) begin
      m_v       <= 1'b0;
      s_v       <= 1'b0;
      main_data <= RESET_VAL;
      skid_data <= RESET_VAL;
    end else if (!m_v) begin
      if (accept) begin
        main_data <= in_data;
        m_v       <= 1'b1;
      end
    end else if (out_ready) begin
      if (s_v) begin
        main_data <= skid_data;
        s_v       <= 1'b0;
      end else if (accept) begin
        main_data <= in_data;
      end else begin
        m_v <= 1'b0;
      end
    end else if (accept) begin
      skid_data <= in_data;
      s_v       <= 1'b1;
    end
  end

endmodule

// File: rtl/elastic_pipe_reg.sv
// Chain of skid stages carrying WIDTH-bit words, plus a count of words held.
module elastic_pipe_reg
  import cla_pkg::*;
#(
  parameter int               WIDTH     = DATA_W,
  parameter int               STAGES    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      Rs,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(STAGES)-1:0]  occupancy
);

  localparam int CW = cnt_w(STAGES);

  logic             chain_valid [STAGES+1];
  logic             chain_ready [STAGES+1];
  logic [WIDTH-1:0] chain_data  [STAGES+1];
  logic             in_fire;
  logic             out_fire;

  assign chain_valid[0]      = in_valid;
  assign chain_data[0]       = in_data;
  assign in_ready            = chain_ready[0];
  assign out_valid           = chain_valid[STAGES];
  assign out_data            = chain_data[STAGES];
  assign chain_ready[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    skid_stage #(
      .WIDTH     (WIDTH),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk       (clk),
      .Rs        (Rs),
      .flush     (flush),
      .in_valid  (chain_valid[k]),
      .in_ready  (chain_ready[k]),
      .in_data   (chain_data[k]),
      .out_valid (chain_valid[k+1]),
      .out_ready (chain_ready[k+1]),
      .out_data  (chain_data[k+1])
    );
  end

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // A flush discards everything, including any transfer that happens on the same edge.
  always_ff @(posedge clk or negedge Rs) begin
    if (!Rs) begin
      occupancy <= '0;
    end else if (flush) begin
      occupancy <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   occupancy <= occupancy + CW'(1);
        2'b01:   occupancy <= occupancy - CW'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

endmodule
